// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths, IDs and types
package rf_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int ZERO_REG = 63;

  typedef logic [ADDR_W-1:0] reg_id_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/write_onehot_6_64.sv
// rtl/write_onehot_6_64.sv - 6-bit register ID to 64-bit one-hot enable decoder
module write_onehot_6_64
  import rf_pkg::*;
(
  input  logic                en,
  input  reg_id_t             addr,
  output logic [NUM_REGS-1:0] onehot
);

  assign onehot = en ? (NUM_REGS'(1) << addr) : '0;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R1W register file with per-register pending scoreboard
// Reads bypass same-cycle writeback; issue reserves destinations to stall RAW/WAW hazards.
module regfile_scoreboard #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int ZERO_REG = rf_pkg::ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic                     rd_ready_a,
  output logic                     rd_ready_b,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic [(1<<ADDR_W)-1:0]   pending
);

  localparam int                NREGS   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ID = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  wr_onehot;
  logic [NREGS-1:0]  rsv_onehot;
  logic              wr_live;
  logic              rsv_live;

  // A same-cycle writeback to the reserved register frees it, so the reservation is accepted.
  assign rsv_ok   = rsv_en & ((rsv_addr == ZERO_ID) | ~pend[rsv_addr] | (wr_en & (wr_addr == rsv_addr)));
  assign wr_live  = wr_en & (wr_addr != ZERO_ID);
  assign rsv_live = rsv_ok & (rsv_addr != ZERO_ID);

  write_onehot_6_64 u_wr_dec (
    .en     (wr_live),
    .addr   (wr_addr),
    .onehot (wr_onehot)
  );

  write_onehot_6_64 u_rsv_dec (
    .en     (rsv_live),
    .addr   (rsv_addr),
    .onehot (rsv_onehot)
  );

  // Reservation set is applied after writeback clear so a same-register reserve wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_onehot[i]) regs[i] <= wr_data;
      end
      pend <= rsv_onehot | (pend & ~wr_onehot);
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (rd_addr_a == ZERO_ID) rd_data_a = '0;
    else if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_b == ZERO_ID) rd_data_b = '0;
    else if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
  end

  assign rd_ready_a = (rd_addr_a == ZERO_ID) | ~pend[rd_addr_a] | (wr_en & (wr_addr == rd_addr_a));
  assign rd_ready_b = (rd_addr_b == ZERO_ID) | ~pend[rd_addr_b] | (wr_en & (wr_addr == rd_addr_b));
  assign pending    = pend;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed plus randomized check of regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;
  import rf_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  reg_id_t             rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
  reg_data_t           rd_data_a, rd_data_b, wr_data;
  logic                rd_ready_a, rd_ready_b, wr_en, rsv_en, rsv_ok;
  logic [NUM_REGS-1:0] pending;

  int n_vec = 0;
  int n_err = 0;

  reg_data_t m_regs [NUM_REGS];
  bit        m_pend [NUM_REGS];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .rd_ready_a (rd_ready_a),
    .rd_ready_b (rd_ready_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rsv_ok     (rsv_ok),
    .pending    (pending)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic reg_data_t exp_data(input int a);
    if (a == ZERO_REG) return '0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_ready(input int a);
    return (a == ZERO_REG) || !m_pend[a] || (wr_en && int'(wr_addr) == a);
  endfunction

  function automatic bit exp_ok();
    return rsv_en && exp_ready(int'(rsv_addr));
  endfunction

  function automatic logic [NUM_REGS-1:0] exp_pending();
    logic [NUM_REGS-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic drive(input logic rn, input logic we, input int wa, input reg_data_t wd,
                       input logic re, input int sa, input int ra, input int rb);
    rst_n = rn; wr_en = we; wr_addr = reg_id_t'(wa); wr_data = wd;
    rsv_en = re; rsv_addr = reg_id_t'(sa); rd_addr_a = reg_id_t'(ra); rd_addr_b = reg_id_t'(rb);
    #1;
    check("m_data_a", rd_data_a, exp_data(ra));
    check("m_data_b", rd_data_b, exp_data(rb));
    check("m_ready_a", rd_ready_a, exp_ready(ra));
    check("m_ready_b", rd_ready_b, exp_ready(rb));
    check("m_rsv_ok", rsv_ok, exp_ok());
    check("m_pending", pending, exp_pending());
  endtask

  task automatic tick();
    bit ok;
    @(posedge clk);
    ok = exp_ok();
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    end else begin
      if (wr_en && int'(wr_addr) != ZERO_REG) begin
        m_regs[wr_addr] = wr_data;
        m_pend[wr_addr] = 0;
      end
      if (ok && int'(rsv_addr) != ZERO_REG) m_pend[rsv_addr] = 1;
    end
    @(negedge clk);
  endtask

  function automatic int pick_addr();
    case ($urandom % 4)
      0:       return ZERO_REG;
      1, 2:    return int'($urandom_range(0, 7));
      default: return int'($urandom % NUM_REGS);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < NUM_REGS; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    rst_n = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    rsv_en = 0; rsv_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    drive(1, 0, 0, '0, 0, 0, 5, 63);
    check("rst_data_a", rd_data_a, 64'h0);
    check("rst_data_b", rd_data_b, 64'h0);
    check("rst_ready", {rd_ready_a, rd_ready_b}, 64'h3);
    check("rst_pending", pending, 64'h0);
    tick();

    drive(1, 1, 5, 64'hDEAD_BEEF, 0, 0, 5, 0);
    check("bypass5", rd_data_a, 64'hDEAD_BEEF);
    tick();
    drive(1, 0, 0, '0, 0, 0, 5, 0);
    check("stored5", rd_data_a, 64'hDEAD_BEEF);
    tick();

    drive(1, 0, 0, '0, 1, 7, 7, 0);
    check("rsv7_ok", rsv_ok, 64'h1);
    tick();
    drive(1, 0, 0, '0, 0, 0, 7, 0);
    check("rsv7_notready", rd_ready_a, 64'h0);
    check("rsv7_pend", pending[7], 64'h1);
    drive(1, 1, 7, 64'h1234, 0, 0, 7, 0);
    check("wb7_ready", rd_ready_a, 64'h1);
    check("wb7_data", rd_data_a, 64'h1234);
    tick();
    drive(1, 0, 0, '0, 0, 0, 7, 0);
    check("wb7_pend_clr", pending[7], 64'h0);
    tick();

    drive(1, 0, 0, '0, 1, 7, 7, 0);
    tick();
    drive(1, 0, 0, '0, 1, 7, 7, 0);
    check("waw_stall", rsv_ok, 64'h0);
    tick();
    drive(1, 0, 0, '0, 0, 0, 7, 0);
    check("waw_pend_same", pending, 64'h80);
    drive(1, 1, 7, 64'h55, 1, 7, 7, 0);
    check("wr_rsv_ok", rsv_ok, 64'h1);
    tick();
    drive(1, 0, 0, '0, 0, 0, 7, 0);
    check("wr_rsv_pend", pending[7], 64'h1);
    check("wr_rsv_data", rd_data_a, 64'h55);
    tick();

    drive(1, 1, 63, 64'hFFFF, 1, 63, 63, 63);
    check("z_data", rd_data_a, 64'h0);
    check("z_ready", rd_ready_a, 64'h1);
    check("z_rsv_ok", rsv_ok, 64'h1);
    tick();
    drive(1, 0, 0, '0, 0, 0, 63, 0);
    check("z_pend", pending[63], 64'h0);
    check("z_data_after", rd_data_a, 64'h0);

    drive(1, 0, 0, '0, 1, 3, 0, 0);
    tick();
    drive(1, 1, 3, 64'hAA, 1, 9, 3, 9);
    tick();
    drive(1, 0, 0, '0, 0, 0, 3, 9);
    check("pre_rst_pend9", pending[9], 64'h1);
    check("pre_rst_data3", rd_data_a, 64'hAA);
    drive(0, 1, 3, 64'h77, 1, 4, 3, 9);
    tick();
    drive(1, 0, 0, '0, 0, 0, 3, 9);
    check("post_rst_pend", pending, 64'h0);
    check("post_rst_data3", rd_data_a, 64'h0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 128) != 0, ($urandom % 3) != 0, pick_addr(), {$urandom, $urandom},
            ($urandom % 2) != 0, pick_addr(), pick_addr(), pick_addr());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Register file for the datapath: 64 entries of 64 bits, two read ports, one write port, and a per-register pending scoreboard. The 6-bit register IDs from decode arrive here, and this block holds the architectural registers they select. Issue logic reserves a destination register when an instruction issues. Writeback clears the reservation. Read ports report per-operand readiness so that issue can stall on read-after-write (RAW) and write-after-write (WAW) hazards.

## Interface
Parameters:
- DATA_W, 64, register width
- ADDR_W, 6, register ID width (2^ADDR_W entries)
- ZERO_REG, 63, hardwired-zero register ID

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- rd_addr_a  in  ADDR_W  read port A register ID
- rd_addr_b  in  ADDR_W  read port B register ID
- rd_data_a  out  DATA_W  port A data (combinational)
- rd_data_b  out  DATA_W  port B data (combinational)
- rd_ready_a  out  1  port A operand valid this cycle
- rd_ready_b  out  1  port B operand valid this cycle
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback register ID
- wr_data  in  DATA_W  writeback data
- rsv_en  in  1  reserve-destination request from issue
- rsv_addr  in  ADDR_W  register ID to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- pending  out  2^ADDR_W  scoreboard bit vector (registered)

## Operation
- Storage: regs[0..63], each DATA_W wide. Scoreboard: pend[0..63], one bit per register.
- Reset (rst_n=0 at an edge):
  - all regs and pend bits clear to 0;
  - wr_en and rsv_en are ignored that cycle;
  - reset wins over any in-flight operation.
- Write, when wr_en=1 and wr_addr != ZERO_REG:
  - regs[wr_addr] <= wr_data and pend[wr_addr] <= 0 at the edge;
  - writing a non-pending register is legal: data updates, pend stays 0.
- Read data, per port:
  - addr == ZERO_REG -> data 0;
  - else wr_en=1 and wr_addr == addr -> data is wr_data (bypass);
  - else data is regs[addr].
- Read ready, per port: ready = (addr == ZERO_REG) | ~pend[addr] | (wr_en & wr_addr == addr).
- Reservation:
  - rsv_ok = rsv_en & (rsv_addr == ZERO_REG | ~pend[rsv_addr] | (wr_en & wr_addr == rsv_addr));
  - when rsv_ok=1 and rsv_addr != ZERO_REG, pend[rsv_addr] <= 1;
  - reserving a register that is already pending, with no same-cycle write, gives rsv_ok=0 and no state change (WAW stall).
- Write and reserve to the same register in the same cycle: data updates, rsv_ok=1, and pend ends at 1 (the new reservation wins).
- Write and reserve to different registers in the same cycle: both take effect independently.
- ZERO_REG:
  - writes to it are dropped;
  - its pend bit is always 0;
  - reserving it returns rsv_ok=rsv_en with no state change.

## Timing
- Read path is fully combinational from rd_addr_*, wr_*, and stored state. There is no read latency.
- Write-to-read latency is 0 cycles via the bypass. Stored data is visible from the next cycle onward.
- Reserve-to-pending latency is 1 cycle: pend is set at the edge, and rd_ready for that register drops the following cycle.
- Writeback-to-ready latency is 0 cycles: rd_ready rises in the same cycle as wr_en.
- Reset values:
  - rd_data_* = 0 for any address;
  - rd_ready_* = 1;
  - rsv_ok = rsv_en;
  - pending = 0.

## Structure
- Shared package rf_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS (=2^ADDR_W), ZERO_REG;
  - typedefs reg_id_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]).
- Sub-module write_onehot_6_64 turns wr_addr/wr_en and rsv_addr/rsv_ok into 64-bit one-hot enables. Instantiate it twice: once for write and once for reserve.
- Read-side selection is a plain 64:1 mux per port, plus the bypass compare.

## Test plan
- Reset, then read rd_addr_a=5, rd_addr_b=63 -> both data 0, both ready 1, pending = 64'h0.
- Write reg 5 = 64'hDEAD_BEEF, reading addr 5 in the same cycle -> rd_data_a = DEAD_BEEF via bypass; next cycle the stored value is still DEAD_BEEF.
- Reserve reg 7 (rsv_ok=1), then read addr 7 next cycle -> rd_ready_a=0 and pending[7]=1. Write reg 7 = 64'h1234 -> the same cycle gives ready 1 and data 1234; next cycle pending[7]=0.
- Reserve reg 7 while it is already pending with no write -> rsv_ok=0 and pending unchanged. Write reg 7 and reserve reg 7 in the same cycle -> rsv_ok=1, data updated, pending[7] stays 1.
- Write reg 63 = 64'hFFFF and reserve reg 63 -> reading 63 gives 0, ready 1, pending[63]=0.
- Reserve regs 3 and 9 and write reg 3 = 64'hAA, then assert rst_n=0 for one cycle -> all pending 0 and reg 3 reads 0.
